deaggregator: RTL and testbench
===============================

# deaggregator

Downstream unpacking stage for the aggregator path. It dequeues wide words of `FETCH_WIDTH` lanes × `DATA_WIDTH` bits from a show-ahead FIFO and emits them one lane per cycle, lane 0 (LSBs) first, into a narrow receiver FIFO. The number of valid lanes per word is set at run time and changes only on word boundaries. It uses the same sender/receiver handshake naming as the aggregator, so the two blocks can be chained.

## Interface
- `DATA_WIDTH`, 8, bits per lane / output word
- `FETCH_WIDTH`, 2, lanes per input word (≥1)
- `CNT_W`, `$clog2(FETCH_WIDTH+1)`, width of fetch-width input
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  synchronous, active-low reset
- `sender_data`  in  FETCH_WIDTH*DATA_WIDTH  wide word, valid whenever `sender_empty_n`=1; lane i at `[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]`
- `sender_empty_n`  in  1  upstream FIFO has data
- `sender_deq`  out  1  pop upstream FIFO this cycle
- `receiver_data`  out  DATA_WIDTH  current lane
- `receiver_full_n`  in  1  downstream FIFO has space
- `receiver_enq`  out  1  push `receiver_data` this cycle
- `change_fetch_width`  in  1  one-cycle request to load a new width
- `input_fetch_width`  in  CNT_W  requested lanes per word

## Operation
- Internal state: `hold` register (wide word), `hold_valid`, lane index `idx` (0..FETCH_WIDTH-1), active width `act_w`, pending width `pend_w` with flag `pend_v`.
- Two states: EMPTY (`hold_valid`=0) and SEND (`hold_valid`=1).
- `receiver_enq` = `hold_valid & receiver_full_n`. `receiver_data` = lane `idx` of `hold`. Both are combinational from registers.
- `last` = (`idx` == `act_w`-1).
- `sender_deq` = `rst_n & sender_empty_n & (!hold_valid | (receiver_enq & last))`.
- EMPTY→SEND: when `sender_deq` is asserted, load `hold` ← `sender_data` and set `idx` ← 0.
- SEND, `receiver_enq` & !`last`: `idx` increments by 1.
- SEND, `receiver_enq` & `last`:
  - if `sender_deq`, reload `hold`, set `idx` ← 0, and stay in SEND (back-to-back, no bubble);
  - otherwise go to EMPTY.
- SEND, `receiver_full_n`=0: hold all state; `receiver_data` stays stable.
- Width change:
  - `change_fetch_width`=1 captures `input_fetch_width` into `pend_w` and sets `pend_v`.
  - `pend_w` is copied to `act_w` (clearing `pend_v`) on the cycle a new word is loaded, or while in EMPTY.
  - It never takes effect in the middle of a word.
  - A second request before application overwrites the first (last wins).
  - Request values of 0 or greater than `FETCH_WIDTH` are clamped to `FETCH_WIDTH`.
- Lanes at index ≥ `act_w` are discarded and never emitted.

## Timing
- Reset (`rst_n`=0 at posedge) gives: `hold_valid`=0, `idx`=0, `act_w`=`FETCH_WIDTH`, `pend_v`=0, `hold`=0.
- Outputs during and immediately after reset: `sender_deq`=0, `receiver_enq`=0, `receiver_data`=0.
- Latency: word dequeued at edge t → lane 0 enqueued in cycle t+1 (if `receiver_full_n`=1) → lane k in cycle t+1+k under no backpressure.
- Throughput: one lane per cycle sustained when upstream is never empty and downstream is never full.
- Upstream empty at word end: `hold_valid` drops and `receiver_enq`=0 from the next cycle until the next dequeue.
- Upstream and downstream events in the same cycle: dequeue and final-lane enqueue together are legal and required for full rate.
- Reset mid-word: the partially sent word is dropped. Nothing further is emitted from it.
- `idx` never exceeds `act_w`-1. No wrap past the word end.

## Configuration
- `DEAGG_LAST_EN` defined:
  - adds output `receiver_last` (1 bit), equal to `hold_valid & last`; it qualifies with `receiver_enq` and is 0 in reset;
  - the downstream consumer uses it as an end-of-word marker.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- `FETCH_WIDTH`=2, `DATA_WIDTH`=8, upstream FIFO preloaded with words 16'h0100, 16'h0302, `receiver_full_n`=1 → `receiver_data` sequence 00, 01, 02, 03 on four consecutive `receiver_enq` cycles; `sender_deq` asserted on the cycle 01 is sent.
- Random `receiver_full_n` (50%) with upstream incrementing lanes 0..N → output is a strict increment by 1 with no gaps or duplicates; `receiver_data` is stable while `receiver_full_n`=0.
- `FETCH_WIDTH`=4: `change_fetch_width` with value 2, pulsed while lane 1 of word 16'h…03020100 is pending → that word still yields 00..03; the next word 07060504 yields only 04, 05.
- Width request 0 and 7 (`FETCH_WIDTH`=4) → `act_w`=4; all four lanes emitted.
- `rst_n`=0 asserted while emitting lane 1 of 16'h0302 → `receiver_enq`=0 next cycle; after release, the next emitted lane is lane 0 of the next FIFO word.
- With `DEAGG_LAST_EN` defined: `receiver_last`=1 exactly on lanes 01 and 03 of the first scenario.

Source files
------------

// File: rtl/deaggregator.sv
// deaggregator: unpacks wide words of FETCH_WIDTH lanes x DATA_WIDTH bits
// from a show-ahead FIFO and pushes them one lane per cycle, lane 0 (LSBs)
// first, into a narrow receiver FIFO. The number of valid lanes per word is
// programmable at run time and only changes on word boundaries.
//
// Ports:
//   clk                 single clock, all logic on posedge
//   rst_n               synchronous active-low reset
//   sender_data         wide word from upstream FIFO (valid when sender_empty_n)
//   sender_empty_n      upstream FIFO has data
//   sender_deq          pop upstream FIFO this cycle
//   receiver_data       current lane
//   receiver_full_n     downstream FIFO has space
//   receiver_enq        push receiver_data this cycle
//   change_fetch_width  one-cycle request to load a new lane count
//   input_fetch_width   requested lanes per word (0 or >FETCH_WIDTH clamp to FETCH_WIDTH)
//   receiver_last       (DEAGG_LAST_EN only) current lane is the last of its word
//
// Optional feature macro: DEAGG_LAST_EN adds the receiver_last output.
module deaggregator #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [CNT_W-1:0]                  input_fetch_width
`ifdef DEAGG_LAST_EN
  ,
  output logic                              receiver_last
`endif
);

  localparam logic [CNT_W-1:0] FW = CNT_W'(FETCH_WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t                          state, state_nxt;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] hold;
  logic [CNT_W-1:0]                idx;
  logic [CNT_W-1:0]                act_w;
  logic [CNT_W-1:0]                pend_w;
  logic                            pend_v;
  logic                            hold_valid;
  logic                            last;
  logic [CNT_W-1:0]                req_w;

  assign hold_valid = (state == SEND);
  assign last       = (idx == act_w - CNT_W'(1));
  assign req_w      = ((input_fetch_width == '0) || (input_fetch_width > FW)) ?
                      FW : input_fetch_width;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (sender_deq) state_nxt = SEND;
      SEND:  if (receiver_enq && last && !sender_deq) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Outputs; sender_deq is gated by rst_n so nothing is popped during reset
  always_comb begin
    receiver_enq = hold_valid & receiver_full_n;
    sender_deq   = rst_n & sender_empty_n & (!hold_valid | (receiver_enq & last));
    receiver_data = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (idx == CNT_W'(i)) receiver_data = hold[i*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef DEAGG_LAST_EN
    receiver_last = hold_valid & last;
`endif
  end

  // Datapath: word holding register, lane index and width bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold   <= '0;
      idx    <= '0;
      act_w  <= FW;
      pend_w <= FW;
      pend_v <= 1'b0;
    end else begin
      if (sender_deq) begin
        hold <= sender_data;
        idx  <= '0;
      end else if (receiver_enq) begin
        // Index parks at 0 when a word finishes without a successor
        idx <= last ? '0 : idx + CNT_W'(1);
      end
      // Width only switches on a word load or while idle; a request in the
      // same cycle is applied at the following opportunity (last request wins)
      if (pend_v && (sender_deq || !hold_valid)) begin
        act_w  <= pend_w;
        pend_v <= 1'b0;
      end
      if (change_fetch_width) begin
        pend_w <= req_w;
        pend_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deaggregator.sv
// Directed bench for deaggregator: a 2-lane and a 4-lane instance, each fed
// by a queue-modelled show-ahead FIFO, with a monitor that logs every lane
// pushed downstream.
module tb_deaggregator;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [15:0] d2_sdata;
  logic        d2_empty_n, d2_deq, d2_full_n, d2_enq, d2_last;
  logic [7:0]  d2_rdata;
  logic        d2_chg;
  logic [1:0]  d2_inw;

  logic [31:0] d4_sdata;
  logic        d4_empty_n, d4_deq, d4_full_n, d4_enq, d4_last;
  logic [7:0]  d4_rdata;
  logic        d4_chg;
  logic [2:0]  d4_inw;

  always #5 clk = ~clk;

  deaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .sender_data(d2_sdata), .sender_empty_n(d2_empty_n), .sender_deq(d2_deq),
    .receiver_data(d2_rdata), .receiver_full_n(d2_full_n), .receiver_enq(d2_enq),
    .change_fetch_width(d2_chg), .input_fetch_width(d2_inw)
`ifdef DEAGG_LAST_EN
    , .receiver_last(d2_last)
`endif
  );

  deaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .sender_data(d4_sdata), .sender_empty_n(d4_empty_n), .sender_deq(d4_deq),
    .receiver_data(d4_rdata), .receiver_full_n(d4_full_n), .receiver_enq(d4_enq),
    .change_fetch_width(d4_chg), .input_fetch_width(d4_inw)
`ifdef DEAGG_LAST_EN
    , .receiver_last(d4_last)
`endif
  );

`ifndef DEAGG_LAST_EN
  assign d2_last = 1'b0;
  assign d4_last = 1'b0;
`endif

  // Upstream FIFO models and downstream logs
  logic [15:0] q2[$];
  logic [31:0] q4[$];
  logic [7:0]  o2_data[$];
  int          o2_cyc[$];
  logic        o2_deq[$];
  logic        o2_last[$];
  int          d2_deq_cyc[$];
  logic [7:0]  o4_data[$];

  int   cyc = 0;
  bit   bp_on = 1'b0;
  bit   hold_chk = 1'b0;
  logic [7:0] hold_val = '0;
  int   stab_n = 0;
  int   stab_bad = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: values sampled here are the ones the DUT presents in the cycle
  // ending at this edge.
  always @(posedge clk) begin
    cyc++;
    if (d2_deq) begin
      void'(q2.pop_front());
      d2_deq_cyc.push_back(cyc);
    end
    if (d2_enq) begin
      o2_data.push_back(d2_rdata);
      o2_cyc.push_back(cyc);
      o2_deq.push_back(d2_deq);
      o2_last.push_back(d2_last);
    end
    if (bp_on) begin
      if (hold_chk) begin
        stab_n++;
        if (d2_rdata !== hold_val) stab_bad++;
      end
      hold_chk = !d2_full_n && (o2_data.size() > 0) && (o2_data.size() < 32);
      hold_val = d2_rdata;
    end else begin
      hold_chk = 1'b0;
    end
    if (d4_deq) void'(q4.pop_front());
    if (d4_enq) o4_data.push_back(d4_rdata);
  end

  // Present the FIFO heads shortly after every clock edge
  always begin
    @(clk);
    #1;
    d2_empty_n = (q2.size() > 0);
    d2_sdata   = (q2.size() > 0) ? q2[0] : 16'h0;
    d4_empty_n = (q4.size() > 0);
    d4_sdata   = (q4.size() > 0) ? q4[0] : 32'h0;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_obs(input bit sel4, input int n);
    for (int i = 0; i < 200; i++) begin
      if ((sel4 ? o4_data.size() : o2_data.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_w4(input logic [2:0] w);
    d4_chg = 1'b1;
    d4_inw = w;
    tick(1);
    d4_chg = 1'b0;
    tick(2);
  endtask

  initial begin
    bit found;
    logic [7:0] exp4[$];
    rst_n     = 1'b0;
    d2_full_n = 1'b1; d4_full_n = 1'b1;
    d2_chg    = 1'b0; d2_inw = '0;
    d4_chg    = 1'b0; d4_inw = '0;
    d2_empty_n = 1'b0; d2_sdata = '0;
    d4_empty_n = 1'b0; d4_sdata = '0;
    q2.push_back(16'h0100);
    q2.push_back(16'h0302);

    // Reset: upstream has data but nothing may move
    tick(3);
    check("rst_deq",   d2_deq,   0);
    check("rst_enq",   d2_enq,   0);
    check("rst_data",  d2_rdata, 0);
    check("rst_enq4",  d4_enq,   0);
    check("rst_data4", d4_rdata, 0);
    check("rst_pops",  q2.size(), 2);
    rst_n = 1'b1;
    check("post_rst_enq",  d2_enq,   0);
    check("post_rst_data", d2_rdata, 0);

    // Two words, no backpressure: 00 01 02 03 back to back
    wait_obs(1'b0, 4);
    tick(4);
    check("s1_count", o2_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s1_data%0d", i), o2_data[i], i);
      check($sformatf("s1_cyc%0d", i), o2_cyc[i], o2_cyc[0] + i);
    end
    check("s1_deq0", o2_deq[0], 0);
    check("s1_deq1", o2_deq[1], 1);
    check("s1_deq2", o2_deq[2], 0);
    check("s1_deq3", o2_deq[3], 0);
    check("s1_latency", o2_cyc[0], d2_deq_cyc[0] + 1);
`ifdef DEAGG_LAST_EN
    check("s1_last0", o2_last[0], 0);
    check("s1_last1", o2_last[1], 1);
    check("s1_last2", o2_last[2], 0);
    check("s1_last3", o2_last[3], 1);
`endif
    check("s1_idle_enq", d2_enq, 0);

    // 4-lane: width requests 1 then 2 mid-word; current word unaffected
    q4.push_back(32'h03020100);
    q4.push_back(32'h07060504);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = d4_enq && (d4_rdata == 8'h00);
    end
    check("s3_sync", found, 1);
    d4_chg = 1'b1; d4_inw = 3'd1;
    tick(1);
    check("s3_lane1", d4_rdata, 8'h01);
    d4_inw = 3'd2;
    tick(1);
    d4_chg = 1'b0;
    wait_obs(1'b1, 6);
    tick(6);
    check("s3_count", o4_data.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("s3_data%0d", i), o4_data[i], i);

    // Clamping: 0 -> 4 lanes, 2 -> 2 lanes, 7 -> 4 lanes
    o4_data.delete();
    pulse_w4(3'd0);
    q4.push_back(32'h0F0E0D0C);
    wait_obs(1'b1, 4);
    tick(2);
    pulse_w4(3'd2);
    q4.push_back(32'h17161514);
    wait_obs(1'b1, 6);
    tick(2);
    pulse_w4(3'd7);
    q4.push_back(32'h13121110);
    wait_obs(1'b1, 10);
    tick(6);
    exp4 = '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h14, 8'h15, 8'h10, 8'h11, 8'h12, 8'h13};
    check("clamp_count", o4_data.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("clamp_data%0d", i), o4_data[i], exp4[i]);

    // Random backpressure over 16 words of incrementing lanes 10..2F
    o2_data.delete(); o2_cyc.delete(); o2_deq.delete(); o2_last.delete();
    for (int k = 0; k < 16; k++) q2.push_back({8'(8'h11 + 2*k), 8'(8'h10 + 2*k)});
    bp_on = 1'b1;
    for (int i = 0; i < 400 && o2_data.size() < 32; i++) begin
      d2_full_n = 1'($urandom_range(0, 1));
      tick(1);
    end
    d2_full_n = 1'b1;
    bp_on = 1'b0;
    tick(4);
    check("bp_count", o2_data.size(), 32);
    for (int i = 0; i < 32; i++) check($sformatf("bp_data%0d", i), o2_data[i], 8'h10 + i);
    check("bp_stable", stab_bad, 0);
    check("bp_stall_seen", (stab_n > 0), 1);

    // Reset while lane 1 of 0302 is presented: rest of that word's stream
    // is abandoned, next FIFO word starts at lane 0
    o2_data.delete(); o2_cyc.delete(); o2_deq.delete(); o2_last.delete();
    q2.push_back(16'h0302);
    q2.push_back(16'h0504);
    q2.push_back(16'h0706);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = d2_enq && (d2_rdata == 8'h03);
    end
    check("s4_sync", found, 1);
    rst_n = 1'b0;
    tick(1);
    check("s4_rst_enq",  d2_enq,   0);
    check("s4_rst_data", d2_rdata, 0);
    rst_n = 1'b1;
    wait_obs(1'b0, 6);
    tick(4);
    check("s4_count", o2_data.size(), 6);
    check("s4_data2", o2_data[2], 8'h04);
    check("s4_data3", o2_data[3], 8'h05);
    check("s4_data4", o2_data[4], 8'h06);
    check("s4_data5", o2_data[5], 8'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
